// File: rtl/commit_trace.sv
// Commit-trace ring buffer fed by the writeback commit stream, drained by a debug pop port.
// Optional retired-commit counter enabled by defining COMMIT_TRACE_RETIRE_CNT_EN.
module commit_trace #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_wb_i,
    input  logic [31:0]     inst_data_wb_i,
    input  logic            clr_i,
    input  logic            rd_en_i,
    output logic            rd_valid_o,
    output logic [XLEN-1:0] rd_pc_o,
    output logic [31:0]     rd_inst_o,
    output logic [AW:0]     count_o,
    output logic            empty_o,
    output logic            full_o,
    output logic            overflow_o,
    output logic            halt_o,
    output logic [63:0]     retire_cnt_o
);

    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [AW:0] FULL_CNT    = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [AW:0]   count_q;
    logic          overflow_q, halt_q;

    logic commit, pop, full, drop;

    always_comb begin
        commit = (pc_wb_i != '0) && (inst_data_wb_i != INST_NOP) && !halt_q;
        pop    = rd_en_i && (count_q != '0);
        full   = (count_q == FULL_CNT);
        // A simultaneous pop frees the slot, so only an unmatched push into a full ring drops.
        drop   = commit && full && !pop;
    end

    // NOTE: the storage array has no reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (commit && !clr_i) begin
            mem[tail_q] <= '{pc: pc_wb_i, inst: inst_data_wb_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_pc_o    <= '0;
            rd_inst_o  <= '0;
        end else if (clr_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= pop;
            if (pop) begin
                rd_pc_o   <= mem[head_q].pc;
                rd_inst_o <= mem[head_q].inst;
            end
            if (pop || drop) begin
                head_q <= head_q + 1'b1;
            end
            if (commit) begin
                tail_q <= tail_q + 1'b1;
                if (inst_data_wb_i == INST_EBREAK) begin
                    halt_q <= 1'b1;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (commit && !pop && !full) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !commit) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifdef COMMIT_TRACE_RETIRE_CNT_EN
    // Counts every qualified commit, independent of the buffer clear.
    logic [63:0] retire_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q <= '0;
        end else if (commit) begin
            retire_q <= retire_q + 64'd1;
        end
    end

    assign retire_cnt_o = retire_q;
`else
    assign retire_cnt_o = 64'd0;
`endif

    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = full;
    assign overflow_o = overflow_q;
    assign halt_o     = halt_q;

endmodule

// File: tb/tb_commit_trace.sv
// Self-checking bench for commit_trace: a queue model of the ring is the scoreboard,
// entries pushed on commit and popped/compared when rd_valid_o appears.
module tb_commit_trace;

    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] pc_wb_i;
    logic [31:0]     inst_data_wb_i;
    logic            clr_i;
    logic            rd_en_i;
    logic            rd_valid_o;
    logic [XLEN-1:0] rd_pc_o;
    logic [31:0]     rd_inst_o;
    logic [AW:0]     count_o;
    logic            empty_o;
    logic            full_o;
    logic            overflow_o;
    logic            halt_o;
    logic [63:0]     retire_cnt_o;

    commit_trace #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_wb_i        (pc_wb_i),
        .inst_data_wb_i (inst_data_wb_i),
        .clr_i          (clr_i),
        .rd_en_i        (rd_en_i),
        .rd_valid_o     (rd_valid_o),
        .rd_pc_o        (rd_pc_o),
        .rd_inst_o      (rd_inst_o),
        .count_o        (count_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .overflow_o     (overflow_o),
        .halt_o         (halt_o),
        .retire_cnt_o   (retire_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        m_valid, m_ovf, m_halt;
    logic [63:0] m_rd_pc, m_retire;
    logic [31:0] m_rd_inst;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_retire();
`ifdef COMMIT_TRACE_RETIRE_CNT_EN
        return m_retire;
`else
        return 64'd0;
`endif
    endfunction

    task automatic model_reset();
        sb.delete();
        m_valid   = 1'b0;
        m_ovf     = 1'b0;
        m_halt    = 1'b0;
        m_rd_pc   = '0;
        m_rd_inst = '0;
        m_retire  = '0;
    endtask

    task automatic check_all(input string ph);
        check({ph, ".rd_valid"}, 64'(rd_valid_o), 64'(m_valid));
        check({ph, ".rd_pc"},    rd_pc_o,          m_rd_pc);
        check({ph, ".rd_inst"},  64'(rd_inst_o),   64'(m_rd_inst));
        check({ph, ".count"},    64'(count_o),     64'(sb.size()));
        check({ph, ".empty"},    64'(empty_o),     64'(sb.size() == 0));
        check({ph, ".full"},     64'(full_o),      64'(sb.size() == DEPTH));
        check({ph, ".overflow"}, 64'(overflow_o),  64'(m_ovf));
        check({ph, ".halt"},     64'(halt_o),      64'(m_halt));
        check({ph, ".retire"},   retire_cnt_o,     exp_retire());
    endtask

    task automatic idle_inputs();
        pc_wb_i        = '0;
        inst_data_wb_i = NOP;
        clr_i          = 1'b0;
        rd_en_i        = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic cycle(input logic [63:0] pc, input logic [31:0] inst,
                         input logic rd, input logic clr, input string ph);
        logic commit, pop;
        ent_t e;
        pc_wb_i        = pc;
        inst_data_wb_i = inst;
        rd_en_i        = rd;
        clr_i          = clr;
        commit = (pc != 0) && (inst != NOP) && !m_halt;
        pop    = rd && (sb.size() > 0);
        m_valid = 1'b0;
        if (commit) m_retire = m_retire + 64'd1;
        if (clr) begin
            sb.delete();
            m_ovf  = 1'b0;
            m_halt = 1'b0;
        end else begin
            if (pop) begin
                e         = sb.pop_front();
                m_rd_pc   = e.pc;
                m_rd_inst = e.inst;
                m_valid   = 1'b1;
            end
            if (commit) begin
                if (sb.size() == DEPTH) begin
                    void'(sb.pop_front());
                    m_ovf = 1'b1;
                end
                sb.push_back('{pc: pc, inst: inst});
                if (inst == EBREAK) m_halt = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_all(ph);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic push of three, then three pops in order.
        for (int i = 0; i < 3; i++)
            cycle(64'h8000_0000 + 64'(4 * i), 32'h0000_0093, 1'b0, 1'b0, "push3");
        check("cnt3", 64'(count_o), 64'd3);
        for (int i = 0; i < 3; i++)
            cycle('0, NOP, 1'b1, 1'b0, "pop3");
        cycle('0, NOP, 1'b0, 1'b0, "after_pop3");
        check("empty_after_pop3", 64'(empty_o), 64'd1);
        cycle('0, NOP, 1'b1, 1'b0, "pop_empty");

        // Non-commits: pc=0 or NOP.
        for (int i = 0; i < 3; i++)
            cycle('0, 32'h0000_0093, 1'b0, 1'b0, "pc_zero");
        for (int i = 0; i < 2; i++)
            cycle(64'h8000_0100, NOP, 1'b0, 1'b0, "nop");

        // Overflow: 18 pushes into a 16-deep ring.
        for (int i = 0; i < 18; i++)
            cycle(64'h8000_0000 + 64'(4 * i), 32'h0000_0093 | (32'(i) << 20), 1'b0, 1'b0, "push18");
        check("ovf_flag", 64'(overflow_o), 64'd1);
        cycle('0, NOP, 1'b1, 1'b0, "ovf_pop");
        check("ovf_first_pc", rd_pc_o, 64'h8000_0008);

        // Full ring, simultaneous push and pop: no drop.
        cycle('0, NOP, 1'b0, 1'b1, "clr1");
        for (int i = 0; i < DEPTH; i++)
            cycle(64'h8000_1000 + 64'(4 * i), 32'h0000_0113 | (32'(i) << 20), 1'b0, 1'b0, "fill");
        cycle(64'h8000_2000, 32'h0000_0193, 1'b1, 1'b0, "full_pushpop");
        check("full_pushpop_pc", rd_pc_o, 64'h8000_1000);
        check("full_pushpop_ovf", 64'(overflow_o), 64'd0);
        for (int i = 0; i < DEPTH; i++)
            cycle('0, NOP, 1'b1, 1'b0, "drain");

        // Empty ring, simultaneous push and pop: pop ignored, push stored.
        cycle(64'h8000_3000, 32'h0000_0213, 1'b1, 1'b0, "empty_pushpop");
        check("empty_pushpop_cnt", 64'(count_o), 64'd1);
        cycle('0, NOP, 1'b1, 1'b0, "empty_pushpop_pop");

        // Halt on ebreak.
        cycle(64'h8000_0010, EBREAK, 1'b0, 1'b0, "ebreak");
        for (int i = 0; i < 4; i++)
            cycle(64'h8000_0014 + 64'(4 * i), 32'h0000_0093, 1'b0, 1'b0, "post_halt");
        check("halt_cnt", 64'(count_o), 64'd1);
        cycle('0, NOP, 1'b1, 1'b0, "halt_pop");
        check("halt_entry", 64'(rd_inst_o), 64'(EBREAK));
        cycle(64'h8000_0040, 32'h0000_0093, 1'b0, 1'b0, "halted_push");
        cycle(64'h8000_0044, 32'h0000_0093, 1'b1, 1'b1, "clr_halt");
        cycle(64'h8000_0048, 32'h0000_0093, 1'b0, 1'b0, "post_clr_push");

        // Reset asserted while a pop is requested.
        cycle(64'h8000_0050, 32'h0000_0093, 1'b0, 1'b0, "pre_rst");
        rd_en_i = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        rd_en_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++)
            cycle('0, NOP, 1'b0, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
